// File: rtl/bp_fe_bht_meta_queue_if.sv
// bp_fe_bht_meta_queue_if
//
// Bundles the prediction push port, the in-order resolve port, the flush
// strobe and the registered BHT write/status outputs of the BHT metadata
// queue into one interface.
//
// Parameters:
//   global_history_length_p  width of the BHT history index
//   els_p                    queue depth (power of two, >= 2)
//
// Signals (direction as seen from the queue):
//   pred_v_i, pred_history_i, pred_taken_i   in   prediction entering flight
//   pred_ready_o                             out  queue not full
//   res_v_i, res_taken_i                     in   oldest branch resolved
//   res_ready_o                              out  queue not empty
//   flush_i                                  in   squash unresolved entries
//   w_v_o, history_w_o, actual_o, correct_o  out  registered BHT update
//   count_o                                  out  current occupancy
//   err_o                                    out  sticky protocol error
//
// Modports:
//   master  the frontend/backend side that drives predictions and resolves
//   slave   the queue itself
interface bp_fe_bht_meta_queue_if
    #(parameter int global_history_length_p = 8
    , parameter int els_p                   = 8
    );

    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic                               pred_v_i;
    logic [global_history_length_p-1:0] pred_history_i;
    logic                               pred_taken_i;
    logic                               pred_ready_o;

    logic                               res_v_i;
    logic                               res_taken_i;
    logic                               res_ready_o;

    logic                               flush_i;

    logic                               w_v_o;
    logic [global_history_length_p-1:0] history_w_o;
    logic                               actual_o;
    logic                               correct_o;
    logic [cnt_w_lp-1:0]                count_o;
    logic                               err_o;

    modport master
        ( output pred_v_i
        , output pred_history_i
        , output pred_taken_i
        , input  pred_ready_o
        , output res_v_i
        , output res_taken_i
        , input  res_ready_o
        , output flush_i
        , input  w_v_o
        , input  history_w_o
        , input  actual_o
        , input  correct_o
        , input  count_o
        , input  err_o
        );

    modport slave
        ( input  pred_v_i
        , input  pred_history_i
        , input  pred_taken_i
        , output pred_ready_o
        , input  res_v_i
        , input  res_taken_i
        , output res_ready_o
        , input  flush_i
        , output w_v_o
        , output history_w_o
        , output actual_o
        , output correct_o
        , output count_o
        , output err_o
        );

endinterface

// File: rtl/bp_fe_bht_meta_queue.sv
// bp_fe_bht_meta_queue
//
// Circular buffer of {history, predicted direction} for every in-flight
// conditional-branch prediction, sitting in front of the global-history
// BHT write port. Entries are pushed when a prediction is made and popped
// in program order when the backend resolves the branch; each pop produces
// a registered one-cycle BHT update carrying the history index, the actual
// direction and whether the prediction was correct.
//
// Ports:
//   clk_i      in  clock, all state changes on the rising edge
//   reset_n_i  in  synchronous active-low reset
//   bus        slave side of bp_fe_bht_meta_queue_if (push, resolve,
//              flush, BHT update, occupancy and error flag)
module bp_fe_bht_meta_queue
    #(parameter int global_history_length_p = 8
    , parameter int els_p                   = 8
    )
    ( input  logic                  clk_i
    , input  logic                  reset_n_i
    , bp_fe_bht_meta_queue_if.slave bus
    );

    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    // Storage, deliberately without reset: contents are only ever read
    // behind the read pointer, which reset forces equal to the write pointer.
    logic [global_history_length_p-1:0] hist_mem  [els_p];
    logic                               taken_mem [els_p];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic [ptr_w_lp-1:0] rptr_next;
    logic [idx_w_lp-1:0] rd_idx, wr_idx;

    logic empty, full;
    logic push, pop;
    logic proto_err;

    logic                               w_v_r;
    logic [global_history_length_p-1:0] history_w_r;
    logic                               actual_r;
    logic                               correct_r;
    logic                               err_r;

    assign rd_idx = rptr_r[idx_w_lp-1:0];
    assign wr_idx = wptr_r[idx_w_lp-1:0];

    assign empty = (rptr_r == wptr_r);
    assign full  = (rptr_r[idx_w_lp-1:0] == wptr_r[idx_w_lp-1:0])
                 & (rptr_r[idx_w_lp] != wptr_r[idx_w_lp]);

    // Ready flags come only from registered pointers: no bypass, so a push
    // into a full queue is refused even if a pop happens in the same cycle,
    // and a resolve on an empty queue is refused even alongside a push.
    assign push = bus.pred_v_i & ~full;
    assign pop  = bus.res_v_i  & ~empty;

    assign rptr_next = rptr_r + ptr_w_lp'(pop);

    assign proto_err = (bus.pred_v_i & full & ~bus.flush_i)
                     | (bus.res_v_i & empty);

    // A push that coincides with a flush is discarded, so it never needs
    // to land in storage.
    always_ff @(posedge clk_i) begin
        if (push & ~bus.flush_i) begin
            hist_mem[wr_idx]  <= bus.pred_history_i;
            taken_mem[wr_idx] <= bus.pred_taken_i;
        end
    end

    // Pointer and BHT-update registers. On flush the pop of that cycle still
    // completes, then the write pointer collapses onto the post-pop read
    // pointer so every remaining entry is dropped.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_r      <= '0;
            wptr_r      <= '0;
            w_v_r       <= 1'b0;
            history_w_r <= '0;
            actual_r    <= 1'b0;
            correct_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            rptr_r <= rptr_next;

            if (bus.flush_i) begin
                wptr_r <= rptr_next;
            end else if (push) begin
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end

            w_v_r <= pop;
            if (pop) begin
                history_w_r <= hist_mem[rd_idx];
                actual_r    <= bus.res_taken_i;
                correct_r   <= (taken_mem[rd_idx] == bus.res_taken_i);
            end

            if (proto_err) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.pred_ready_o = ~full;
    assign bus.res_ready_o  = ~empty;
    assign bus.w_v_o        = w_v_r;
    assign bus.history_w_o  = history_w_r;
    assign bus.actual_o     = actual_r;
    assign bus.correct_o    = correct_r;
    assign bus.err_o        = err_r;

    // Modular pointer difference is the occupancy, including across wrap.
    assign bus.count_o = cnt_w_lp'(wptr_r - rptr_r);

endmodule

// File: tb/tb_bp_fe_bht_meta_queue.sv
// tb_bp_fe_bht_meta_queue
//
// Self-checking bench for bp_fe_bht_meta_queue (history width 8, depth 8).
// A constant vector table covers the basic push/resolve and full-queue
// behaviour, hand-written sequences cover wrap, flush, empty-resolve and
// mid-operation reset, and a randomized phase is checked against a
// queue-based reference model.
module tb_bp_fe_bht_meta_queue;

    localparam int HW  = 8;
    localparam int ELS = 8;

    logic clk;
    logic rst_n;

    bp_fe_bht_meta_queue_if #(.global_history_length_p(HW), .els_p(ELS)) bus ();

    bp_fe_bht_meta_queue #(.global_history_length_p(HW), .els_p(ELS)) dut
        ( .clk_i     (clk)
        , .reset_n_i (rst_n)
        , .bus       (bus)
        );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of in-flight predictions plus the
    // last BHT update and the sticky error flag.
    typedef struct packed {
        logic [HW-1:0] h;
        logic          t;
    } ent_t;

    ent_t          mq[$];
    logic          mWv, mAct, mCor, mErr;
    logic [HW-1:0] mHist;

    int nCompared   = 0;
    int nMismatched = 0;

    function automatic void checkVal(input string name, input logic [31:0] act,
                                     input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void modelEdge(input logic rn, input logic pv, input logic [HW-1:0] ph,
                                      input logic pt, input logic rv, input logic rt,
                                      input logic fl);
        bit   isFull, isEmpty;
        ent_t e;
        if (!rn) begin
            mq.delete();
            mWv = 0; mHist = '0; mAct = 0; mCor = 0; mErr = 0;
            return;
        end
        isFull  = (mq.size() == ELS);
        isEmpty = (mq.size() == 0);
        if ((pv && isFull && !fl) || (rv && isEmpty)) mErr = 1;
        if (rv && !isEmpty) begin
            e     = mq.pop_front();
            mWv   = 1;
            mHist = e.h;
            mAct  = rt;
            mCor  = (e.t == rt);
        end else begin
            mWv = 0;
        end
        if (fl) mq.delete();
        else if (pv && !isFull) mq.push_back('{h: ph, t: pt});
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, and
    // leave time 1 unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic rn, input logic pv, input logic [HW-1:0] ph,
                                 input logic pt, input logic rv, input logic rt,
                                 input logic fl);
        rst_n              = rn;
        bus.pred_v_i       = pv;
        bus.pred_history_i = ph;
        bus.pred_taken_i   = pt;
        bus.res_v_i        = rv;
        bus.res_taken_i    = rt;
        bus.flush_i        = fl;
        @(posedge clk);
        modelEdge(rn, pv, ph, pt, rv, rt, fl);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".w_v"},        32'(bus.w_v_o),        32'(mWv));
        checkVal({tag, ".history_w"},  32'(bus.history_w_o),  32'(mHist));
        checkVal({tag, ".actual"},     32'(bus.actual_o),     32'(mAct));
        checkVal({tag, ".correct"},    32'(bus.correct_o),    32'(mCor));
        checkVal({tag, ".count"},      32'(bus.count_o),      32'(mq.size()));
        checkVal({tag, ".err"},        32'(bus.err_o),        32'(mErr));
        checkVal({tag, ".pred_ready"}, 32'(bus.pred_ready_o), 32'(mq.size() != ELS));
        checkVal({tag, ".res_ready"},  32'(bus.res_ready_o),  32'(mq.size() != 0));
    endtask

    typedef struct {
        logic          rn, pv, pt, rv, rt, fl;
        logic [HW-1:0] ph;
        logic          eWv, eAct, eCor, eErr, ePr, eRr;
        logic [HW-1:0] eHist;
        int            eCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic pv, input logic [HW-1:0] ph, input logic pt,
                                   input logic rv, input logic rt,
                                   input logic eWv, input logic [HW-1:0] eHist,
                                   input logic eAct, input logic eCor, input int eCnt,
                                   input logic eErr);
        vec_t v;
        v.rn = 1; v.pv = pv; v.ph = ph; v.pt = pt; v.rv = rv; v.rt = rt; v.fl = 0;
        v.eWv = eWv; v.eHist = eHist; v.eAct = eAct; v.eCor = eCor;
        v.eCnt = eCnt; v.eErr = eErr;
        v.ePr = (eCnt != ELS);
        v.eRr = (eCnt != 0);
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Basic push/resolve, full queue, overflow attempt, in-order drain.
        addVec(1, 8'h3C, 1, 0, 0,  0, 8'h00, 0, 0, 1, 0);
        addVec(0, 8'h00, 0, 1, 1,  1, 8'h3C, 1, 1, 0, 0);
        addVec(0, 8'h00, 0, 0, 0,  0, 8'h3C, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            addVec(1, HW'(i), ((i % 2) == 0), 0, 0,  0, 8'h3C, 1, 1, i + 1, 0);
        addVec(1, 8'h99, 1, 0, 0,  0, 8'h3C, 1, 1, 8, 1);
        for (int i = 0; i < 8; i++)
            addVec(0, 8'h00, 0, 1, 1,  1, HW'(i), 1, ((i % 2) == 0), 7 - i, 1);
        addVec(0, 8'h00, 0, 0, 0,  0, 8'h07, 1, 0, 0, 1);

        // Reset state
        applyStimulus(0, 1, 8'hFF, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("rst.w_v",       32'(bus.w_v_o),        0);
        checkVal("rst.history_w", 32'(bus.history_w_o),  0);
        checkVal("rst.count",     32'(bus.count_o),      0);
        checkVal("rst.err",       32'(bus.err_o),        0);
        checkVal("rst.pred_rdy",  32'(bus.pred_ready_o), 1);
        checkVal("rst.res_rdy",   32'(bus.res_ready_o),  0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rn, vecs[k].pv, vecs[k].ph, vecs[k].pt,
                          vecs[k].rv, vecs[k].rt, vecs[k].fl);
            checkVal($sformatf("vec%0d.w_v", k),        32'(bus.w_v_o),        32'(vecs[k].eWv));
            checkVal($sformatf("vec%0d.history_w", k),  32'(bus.history_w_o),  32'(vecs[k].eHist));
            checkVal($sformatf("vec%0d.actual", k),     32'(bus.actual_o),     32'(vecs[k].eAct));
            checkVal($sformatf("vec%0d.correct", k),    32'(bus.correct_o),    32'(vecs[k].eCor));
            checkVal($sformatf("vec%0d.count", k),      32'(bus.count_o),      32'(vecs[k].eCnt));
            checkVal($sformatf("vec%0d.err", k),        32'(bus.err_o),        32'(vecs[k].eErr));
            checkVal($sformatf("vec%0d.pred_ready", k), 32'(bus.pred_ready_o), 32'(vecs[k].ePr));
            checkVal($sformatf("vec%0d.res_ready", k),  32'(bus.res_ready_o),  32'(vecs[k].eRr));
        end

        // Wrap-around: count 3, then 20 cycles of simultaneous push and pop
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, HW'(8'h40 + i), i[0], 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, HW'(8'h50 + i), $urandom_range(1), 1, $urandom_range(1), 0);
            checkOutput($sformatf("wrap%0d", i));
        end
        checkVal("wrap.count_end", 32'(bus.count_o), 3);
        checkVal("wrap.last_hist", 32'(bus.history_w_o), 32'h50 + 16);

        // Flush with a same-cycle pop and push
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, HW'(8'hA0 + i), 1, 0, 0, 0);
        applyStimulus(1, 1, 8'hEE, 0, 1, 0, 1);
        checkOutput("flush");
        checkVal("flush.w_v",     32'(bus.w_v_o),       1);
        checkVal("flush.hist",    32'(bus.history_w_o), 32'hA0);
        checkVal("flush.correct", 32'(bus.correct_o),   0);
        checkVal("flush.count",   32'(bus.count_o),     0);
        checkVal("flush.res_rdy", 32'(bus.res_ready_o), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("flush_after");

        // Resolve while empty: no update, sticky error until reset
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkVal("empty_res.w_v", 32'(bus.w_v_o), 0);
        checkVal("empty_res.err", 32'(bus.err_o), 1);
        applyStimulus(1, 1, 8'h11, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkOutput("err_sticky");
        checkVal("err_sticky.err", 32'(bus.err_o), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("err_cleared", 32'(bus.err_o), 0);

        // Mid-operation reset with a same-cycle resolve
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, HW'(8'hC0 + i), 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("midrst");
        checkVal("midrst.w_v",   32'(bus.w_v_o),   0);
        checkVal("midrst.count", 32'(bus.count_o), 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        checkOutput("midrst_after");

        // Randomized traffic against the reference model
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(63) != 0,
                          $urandom_range(99) < 60,
                          HW'($urandom),
                          $urandom_range(1),
                          $urandom_range(99) < 55,
                          $urandom_range(1),
                          $urandom_range(15) == 0);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/bp_fe_bht_meta_queue.md
# bp_fe_bht_meta_queue

Sits directly upstream of the frontend global-history BHT's write port. It records the history metadata and predicted direction for every in-flight conditional-branch prediction in a circular buffer. It pops the oldest entry when the backend resolves that branch in program order. It then drives a registered one-cycle BHT update: write valid, history index, actual direction and a correct/incorrect flag.

## Interface
- global_history_length_p, default 8: width of the BHT history index; must match the downstream BHT.
- els_p, default 8: queue depth; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- pred_v_i  in  1  a prediction enters flight this cycle.
- pred_history_i  in  global_history_length_p  history metadata returned with the prediction.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  queue not full.
- res_v_i  in  1  oldest in-flight branch resolved this cycle.
- res_taken_i  in  1  actual direction.
- res_ready_o  out  1  queue not empty.
- flush_i  in  1  squash all unresolved entries.
- w_v_o  out  1  BHT write valid.
- history_w_o  out  global_history_length_p  BHT write index.
- actual_o  out  1  actual direction to the BHT.
- correct_o  out  1  prediction matched outcome.
- count_o  out  $clog2(els_p+1)  current occupancy.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Storage: els_p entries of {history, taken}. Read and write pointers are log2(els_p)+1 bits; the extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Push: fires on pred_v_i & pred_ready_o. It writes the entry at wptr and increments wptr.
- Pop: fires on res_v_i & res_ready_o. It reads the entry at rptr and increments rptr. Next cycle:
  - w_v_o=1
  - history_w_o=entry.history
  - actual_o=res_taken_i
  - correct_o=(entry.taken==res_taken_i)
- With no pop, w_v_o=0 next cycle. The other outputs hold their last values.
- pred_ready_o = ~full and res_ready_o = ~empty, both combinational from registered state only. There is no bypass:
  - a push into a full queue is not accepted, even with a same-cycle pop;
  - a resolve while empty is not accepted, even with a same-cycle push.
- Simultaneous push and pop on a non-empty, non-full queue: both occur and the count is unchanged.
- Flush, same-cycle priority:
  - a valid pop in the flush cycle completes and produces its BHT update;
  - then all remaining entries are dropped (wptr <= rptr after pop), count becomes 0, and any same-cycle push is discarded.
- err_o sets on either of these and stays set until reset:
  - pred_v_i while full and not flushing;
  - res_v_i while empty.
- Pointer wrap: the low bits wrap modulo els_p and the MSB toggles. Entry ordering is preserved across the wrap.
- Reset (reset_n_i=0 at an edge): pointers=0, count_o=0, w_v_o=0, history_w_o=0, actual_o=0, correct_o=0, err_o=0. Storage contents are don't-care. Reset overrides push, pop and flush in the same cycle. Mid-operation reset discards all entries, and no BHT write is issued in the cycle after reset.

## Timing
- Push at edge N: count_o and res_ready_o reflect it after edge N. The earliest pop of that entry is at edge N+1.
- Pop at edge N: w_v_o is high for exactly the cycle after edge N. Pops on back-to-back edges give back-to-back w_v_o pulses, one per pop.
- pred_ready_o and res_ready_o have no combinational path from any input.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then push {hist=0x3C, taken=1} and resolve taken=1 the next cycle -> one cycle later w_v_o=1, history_w_o=0x3C, actual_o=1, correct_o=1; the cycle after, w_v_o=0.
- Push 8 entries (els_p=8) with hist 0..7 and pred_taken alternating 1,0 -> pred_ready_o=0, count_o=8.
  - A 9th pred_v_i sets err_o=1 and leaves count_o=8.
  - Resolve all 8 with taken=1 -> 8 consecutive w_v_o pulses, history 0..7 in order, correct_o pattern 1,0,1,0,...
- Wrap-around: 20 cycles of simultaneous push and pop starting from count 3 -> count_o stays 3 and updates come out in FIFO order across the pointer wrap.
- Push 5 entries, then in one cycle assert flush_i with res_v_i=1 (res_taken_i opposite to entry 0's pred_taken) and pred_v_i=1 -> next cycle w_v_o=1 for entry 0 with correct_o=0; count_o=0, res_ready_o=0.
- res_v_i with the queue empty -> no w_v_o pulse, err_o=1; only reset clears err_o.
- Assert reset_n_i=0 with 4 entries queued and res_v_i=1 -> next cycle w_v_o=0, count_o=0, all outputs at their reset values.
